usb_kbd_event_queue: RTL

Sits directly downstream of the 12 MHz USB clock PLL, in the USB clock domain, next to the low-speed HID host. It takes 8-byte boot-protocol keyboard reports and diffs each one against the previous report. Newly pressed keys become discrete events in a small first-word-fall-through FIFO, which the CPU-side bridge drains.

---
 rtl/usb_kbd_pkg.sv | 18 +
 rtl/kbd_evt_fifo.sv | 44 ++++
 rtl/usb_kbd_event_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/usb_kbd_pkg.sv
// usb_kbd_pkg: shared constants, state enum and event layout for the keyboard event queue.
package usb_kbd_pkg;
  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
  localparam int EVT_W = 17;
  localparam int EVT_KEY_LSB = 0;
  localparam int EVT_MOD_LSB = 8;
  localparam int EVT_REL_BIT = 16;
  typedef enum logic [1:0] {IDLE, SCAN_NEW, SCAN_OLD, COMMIT} state_e;
  function automatic logic [EVT_W-1:0] make_evt(input logic rel, input logic [7:0] mods, input logic [7:0] key);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_REL_BIT] = rel;
    e[EVT_MOD_LSB+:8] = mods;
    e[EVT_KEY_LSB+:8] = key;
    return e;
  endfunction
endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module kbd_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic         full_o,
  output logic         drop_o,
  output logic [W-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic pop, wr;
  always_comb begin
    pop = ready_i && cnt_q != '0;
    wr = push_i && (!full_o || pop);
    wr_d = wr_q + AW'(wr);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) if (wr) mem_q[wr_q] <= data_i;
  assign valid_o = cnt_q != '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign drop_o = push_i && !wr;
  assign data_o = valid_o ? mem_q[rd_q] : '0;
endmodule

// File: rtl/usb_kbd_event_queue.sv
// usb_kbd_event_queue: diffs boot-protocol keyboard reports against the previous one and queues press events.
// Define USB_KBD_RELEASE_EV_EN to also emit release events for keys that disappeared.
module usb_kbd_event_queue
  import usb_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SLOTS = 6
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               conn_i,
  input  logic               report_valid_i,
  input  logic [7:0]         modifiers_i,
  input  logic [8*SLOTS-1:0] keys_i,
  output logic               busy_o,
  output logic               evt_valid_o,
  output logic [EVT_W-1:0]   evt_data_o,
  input  logic               evt_ready_i,
  output logic               overrun_o
);
`ifdef USB_KBD_RELEASE_EV_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] mod_q, mod_d;
  logic [8*SLOTS-1:0] cur_q, cur_d, prev_q, prev_d, other;
  logic push_q, push_d, ovr_q, ovr_d;
  logic [EVT_W-1:0] pdata_q, pdata_d;
  logic err, scanning, accept, in_other, dup, fifo_drop, fifo_full;
  logic [7:0] key;
  always_comb begin
    err = 1'b0;
    for (int s = 0; s < SLOTS; s++) err |= keys_i[8*s+:8] == KEY_ERR_ROLLOVER;
    scanning = state_q == SCAN_NEW || state_q == SCAN_OLD;
    accept = report_valid_i && conn_i && !scanning && !err;
    key = state_q == SCAN_OLD ? prev_q[8*idx_q+:8] : cur_q[8*idx_q+:8];
    other = state_q == SCAN_OLD ? cur_q : prev_q;
    in_other = 1'b0;
    dup = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      in_other |= other[8*s+:8] == key;
      dup |= IW'(s) < idx_q && cur_q[8*s+:8] == key;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    mod_d = mod_q;
    cur_d = cur_q;
    prev_d = prev_q;
    push_d = 1'b0;
    pdata_d = make_evt(REL_EN && state_q == SCAN_OLD, mod_q, key);
    ovr_d = ovr_q || fifo_drop || (report_valid_i && scanning);
    if (state_q == COMMIT) begin
      prev_d = cur_q;
      state_d = IDLE;
    end
    if (scanning) begin
      push_d = key != KEY_NONE && !in_other && !(state_q == SCAN_NEW && dup);
      idx_d = idx_q == IW'(SLOTS-1) ? '0 : idx_q + 1'b1;
      if (idx_q == IW'(SLOTS-1)) state_d = REL_EN && state_q == SCAN_NEW ? SCAN_OLD : COMMIT;
    end
    if (accept) begin
      mod_d = modifiers_i;
      cur_d = keys_i;
      idx_d = '0;
      state_d = SCAN_NEW;
    end
    // Disconnect abandons the scan and forgets the held keys; queued events stay.
    if (!conn_i) begin
      state_d = IDLE;
      idx_d = '0;
      prev_d = '0;
      push_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      mod_q <= '0;
      cur_q <= '0;
      prev_q <= '0;
      push_q <= 1'b0;
      pdata_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mod_q <= mod_d;
      cur_q <= cur_d;
      prev_q <= prev_d;
      push_q <= push_d;
      pdata_q <= pdata_d;
      ovr_q <= ovr_d;
    end
  end
  kbd_evt_fifo #(.DEPTH(DEPTH), .W(EVT_W)) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (push_q),
    .data_i (pdata_q),
    .ready_i(evt_ready_i),
    .valid_o(evt_valid_o),
    .full_o (fifo_full),
    .drop_o (fifo_drop),
    .data_o (evt_data_o)
  );
  assign busy_o = scanning;
  assign overrun_o = ovr_q;
endmodule
